sorted_streamer: RTL and testbench

SORTED_STREAMER -- requirements
Module: sorted_streamer

---
 rtl/sorted_streamer.sv | 118 +++++++++++
 tb/tb_sorted_streamer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_streamer.sv
// Captures a sorted batch on sort_done_i and streams it one element per
// valid/ready transfer, with batch min/median/max and sticky error flags.
module sorted_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_SIZE  = 9
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic [DATA_SIZE-1:0][DATA_WIDTH-1:0]  numbers_i,
  input  logic                                  sort_done_i,
  output logic [DATA_WIDTH-1:0]                 data_o,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic                                  last_o,
  output logic [$clog2(DATA_SIZE)-1:0]          idx_o,
  output logic [DATA_WIDTH-1:0]                 min_o,
  output logic [DATA_WIDTH-1:0]                 max_o,
  output logic [DATA_WIDTH-1:0]                 median_o,
  output logic                                  stats_valid_o,
  output logic                                  busy_o,
  output logic                                  overrun_o,
  output logic                                  order_err_o,
  input  logic                                  clr_flags_i
);

  localparam int IDX_W = $clog2(DATA_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_SIZE - 1);
  localparam int MED_IDX = (DATA_SIZE - 1) / 2;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] buf_reg [DATA_SIZE];

  logic [DATA_SIZE-2:0]  pair_bad;
  logic                  order_bad;
  logic                  xfer;
  logic                  capture;
  logic                  overrun_set;
  logic [IDX_W-1:0]      idx_inc;

  // One comparator per adjacent pair; any descent flags the batch.
  generate
    for (genvar gi = 0; gi < DATA_SIZE - 1; gi++) begin : g_order
      assign pair_bad[gi] = numbers_i[gi] > numbers_i[gi+1];
    end
  endgenerate

  assign order_bad   = |pair_bad;
  assign xfer        = valid_o && ready_i;
  // A new batch is accepted when idle, or seamlessly on the final transfer.
  assign capture     = sort_done_i && ((state_reg == IDLE) || (xfer && last_o));
  assign overrun_set = sort_done_i && (state_reg == STREAM) && !capture;
  assign idx_inc     = idx_o + IDX_W'(1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg     <= IDLE;
      data_o        <= '0;
      valid_o       <= 1'b0;
      last_o        <= 1'b0;
      idx_o         <= '0;
      min_o         <= '0;
      max_o         <= '0;
      median_o      <= '0;
      stats_valid_o <= 1'b0;
      busy_o        <= 1'b0;
      overrun_o     <= 1'b0;
      order_err_o   <= 1'b0;
      for (int k = 0; k < DATA_SIZE; k++) begin
        buf_reg[k] <= '0;
      end
    end else begin
      if (capture) begin
        for (int k = 0; k < DATA_SIZE; k++) begin
          buf_reg[k] <= numbers_i[k];
        end
        state_reg     <= STREAM;
        valid_o       <= 1'b1;
        busy_o        <= 1'b1;
        idx_o         <= '0;
        data_o        <= numbers_i[0];
        last_o        <= 1'b0;
        min_o         <= numbers_i[0];
        max_o         <= numbers_i[DATA_SIZE-1];
        median_o      <= numbers_i[MED_IDX];
        stats_valid_o <= 1'b1;
      end else if ((state_reg == STREAM) && xfer) begin
        if (last_o) begin
          state_reg <= IDLE;
          valid_o   <= 1'b0;
          busy_o    <= 1'b0;
          last_o    <= 1'b0;
          idx_o     <= '0;
          data_o    <= '0;
        end else begin
          idx_o  <= idx_inc;
          data_o <= buf_reg[idx_inc];
          last_o <= (idx_inc == LAST_IDX);
        end
      end

      // Set events take priority over a simultaneous clear.
      if (overrun_set) begin
        overrun_o <= 1'b1;
      end else if (clr_flags_i) begin
        overrun_o <= 1'b0;
      end

      if (capture && order_bad) begin
        order_err_o <= 1'b1;
      end else if (clr_flags_i) begin
        order_err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sorted_streamer.sv
// Scoreboard bench for sorted_streamer: stimulus queues expected elements,
// a negedge monitor pops and compares on each valid&&ready transfer.
module tb_sorted_streamer;

  typedef logic [8:0][7:0] batch_t;
  typedef struct {
    logic [7:0] d;
    logic [3:0] i;
    logic       l;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  batch_t      numbers_i;
  logic        sort_done_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;
  logic [3:0]  idx_o;
  logic [7:0]  min_o, max_o, median_o;
  logic        stats_valid_o, busy_o, overrun_o, order_err_o;
  logic        clr_flags_i;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  sorted_streamer #(.DATA_WIDTH(8), .DATA_SIZE(9)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .numbers_i(numbers_i),
    .sort_done_i(sort_done_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .last_o(last_o), .idx_o(idx_o), .min_o(min_o),
    .max_o(max_o), .median_o(median_o), .stats_valid_o(stats_valid_o),
    .busy_o(busy_o), .overrun_o(overrun_o), .order_err_o(order_err_o),
    .clr_flags_i(clr_flags_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on transfers, plus hold-stability under stall.
  logic       stall_prev = 1'b0;
  logic [7:0] hold_d;
  logic [3:0] hold_i;
  logic       hold_l;
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && valid_o) begin
        chk("hold_data", data_o, hold_d);
        chk("hold_idx", idx_o, hold_i);
        chk("hold_last", last_o, hold_l);
      end
      if (valid_o && ready_i) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer: got data %0d expected no transfer", data_o);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("xfer_data", data_o, e.d);
          chk("xfer_idx", idx_o, e.i);
          chk("xfer_last", last_o, e.l);
          $display("xfer data=%0d idx=%0d last=%0d", data_o, idx_o, last_o);
        end
      end
      stall_prev = valid_o && !ready_i;
      hold_d = data_o;
      hold_i = idx_o;
      hold_l = last_o;
    end
  end

  function automatic batch_t make_seq(input int base);
    batch_t b;
    for (int k = 0; k < 9; k++) b[k] = 8'(base + k);
    return b;
  endfunction

  task automatic pulse(input batch_t b, input bit accept);
    numbers_i   = b;
    sort_done_i = 1'b1;
    if (accept) begin
      for (int k = 0; k < 9; k++) begin
        exp_t e;
        e.d = b[k];
        e.i = 4'(k);
        e.l = (k == 8);
        sb_q.push_back(e);
      end
    end
    @(posedge clk_i); #1;
    sort_done_i = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    for (n = 0; n < 100; n++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk_i); #1;
    end
    chk({nm, "_drain_left"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int n;
    for (n = 0; n < 50; n++) begin
      if (valid_o && idx_o == target) break;
      @(posedge clk_i); #1;
    end
    chk("wait_idx_reached", idx_o, target);
  endtask

  task automatic chk_stats(input string nm, input logic [7:0] mn, input logic [7:0] md, input logic [7:0] mx);
    chk({nm, "_min"}, min_o, mn);
    chk({nm, "_median"}, median_o, md);
    chk({nm, "_max"}, max_o, mx);
    chk({nm, "_stats_valid"}, stats_valid_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    batch_t b;
    bit     seen_valid;
    rstn_i = 1'b0; numbers_i = '0; sort_done_i = 1'b0;
    ready_i = 1'b0; clr_flags_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_stats_valid", stats_valid_o, 0);
    chk("rst_data", data_o, 0);
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Continuous ready: 9 back-to-back beats starting one cycle after the pulse.
    ready_i = 1'b1;
    chk("s1_pre_valid", valid_o, 0);
    pulse(make_seq(1), 1);
    for (int i = 0; i < 9; i++) begin
      chk("s1_valid", valid_o, 1);
      chk("s1_busy", busy_o, 1);
      chk("s1_idx", idx_o, i);
      @(posedge clk_i); #1;
    end
    chk("s1_end_valid", valid_o, 0);
    chk("s1_end_busy", busy_o, 0);
    chk("s1_sb_empty", sb_q.size(), 0);
    chk_stats("s1", 1, 5, 9);

    // Ready toggling 1,0,1,0: monitor checks hold and exactly-once delivery.
    pulse(make_seq(1), 1);
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0) break;
      ready_i = (i % 2 == 0);
      @(posedge clk_i); #1;
    end
    wait_drain("s2");
    chk("s2_end_valid", valid_o, 0);
    ready_i = 1'b1;

    // Overrun at idx 4, with a simultaneous clear that must lose.
    pulse(make_seq(1), 1);
    wait_idx(4);
    numbers_i = make_seq(100);
    sort_done_i = 1'b1;
    clr_flags_i = 1'b1;
    @(posedge clk_i); #1;
    sort_done_i = 1'b0;
    clr_flags_i = 1'b0;
    chk("s3_overrun_set", overrun_o, 1);
    chk("s3_order_err", order_err_o, 0);
    wait_drain("s3");
    chk_stats("s3", 1, 5, 9);
    clr_flags_i = 1'b1;
    @(posedge clk_i); #1;
    clr_flags_i = 1'b0;
    chk("s3_overrun_clr", overrun_o, 0);

    // Back-to-back batch on the last transfer: no bubble.
    pulse(make_seq(1), 1);
    wait_idx(8);
    chk("s4_last", last_o, 1);
    pulse(make_seq(10), 1);
    chk("s4_valid", valid_o, 1);
    chk("s4_idx", idx_o, 0);
    chk("s4_data", data_o, 10);
    chk("s4_overrun", overrun_o, 0);
    wait_drain("s4");
    chk_stats("s4", 10, 14, 18);

    // Out-of-order batch streams unchanged and raises order_err_o.
    b = make_seq(1);
    b[0] = 8'd3; b[1] = 8'd1; b[2] = 8'd2;
    pulse(b, 1);
    chk("s5_order_err", order_err_o, 1);
    wait_drain("s5");
    chk_stats("s5", 3, 5, 9);
    clr_flags_i = 1'b1;
    @(posedge clk_i); #1;
    clr_flags_i = 1'b0;
    chk("s5_order_clr", order_err_o, 0);

    // Asynchronous reset mid-stream abandons the batch.
    pulse(make_seq(1), 1);
    wait_idx(3);
    rstn_i = 1'b0;
    #1;
    chk("s6_valid", valid_o, 0);
    chk("s6_busy", busy_o, 0);
    chk("s6_idx", idx_o, 0);
    chk("s6_data", data_o, 0);
    chk("s6_min", min_o, 0);
    chk("s6_max", max_o, 0);
    chk("s6_median", median_o, 0);
    chk("s6_stats_valid", stats_valid_o, 0);
    sb_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) seen_valid = 1'b1;
    end
    chk("s6_idle_after_rst", seen_valid, 0);
    pulse(make_seq(20), 1);
    chk("s6_restart_data", data_o, 20);
    wait_drain("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
